dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port byte-addressed data memory between two requesters:
//  port 0 = core load/store path, port 1 = DMA/program-loader path.
//  Port 0 has fixed priority; a starvation counter forces a grant to port 1.
//  Checks alignment, drives the memory's addr/wdata/funct3/write_en, and
//  returns registered read data one cycle after grant.
// PARAMETERS
//  ADDR_W        11  byte-address width (memory depth 2**ADDR_W bytes)
//  STARVE_LIMIT  4   max consecutive port-0 grants while port 1 waits (>=1)
// PORTS
//  i_clk           in   1       clock, all state updates on rising edge
//  i_rst_n         in   1       synchronous reset, active-low
//  i_rN_req        in   1       N=0,1: access request, held until granted
//  i_rN_we         in   1       1=store, 0=load
//  i_rN_addr       in   ADDR_W  byte address
//  i_rN_wdata      in   32      store data, little-endian, LSB-aligned
//  i_rN_funct3     in   3       000 B, 001 H, 010 W, 011 BU, 100 HU
//  o_rN_gnt        out  1       access performed this cycle (comb.)
//  o_rN_rvalid     out  1       read response/error valid, 1-cycle pulse
//  o_rN_rdata      out  32      registered load data (0 on error)
//  o_rN_err        out  1       misaligned/illegal access, with rvalid
//  o_mem_addr      out  ADDR_W  to memory address
//  o_mem_wdata     out  32      to memory write data
//  o_mem_funct3    out  3       to memory funct3
//  o_mem_we        out  1       to memory write enable
//  i_mem_rdata     in   32      combinational read data from memory
// BEHAVIOUR
//  - Reset (i_rst_n=0 at an edge): rvalid/err/rdata regs <=0, starve cnt <=0.
//    While i_rst_n=0: both gnt=0, o_mem_we=0 (combinational qualification).
//  - Arbitration, per cycle: grant r1 if r1_req and (!r0_req or
//    cnt==STARVE_LIMIT); else grant r0 if r0_req. At most one gnt high.
//  - cnt: +1 on r0 grant while r1_req=1; cleared on r1 grant or r1_req=0;
//    saturates at STARVE_LIMIT.
//  - Transfer = req & gnt, same cycle. Granted port's addr/wdata/funct3
//    muxed to o_mem_*; no grant: o_mem_* = 0.
//  - Legality: size B (000,011) any addr; H (001,100) addr[0]=0;
//    W (010) addr[1:0]=00. Stores: funct3 101..111, 011 or 100 illegal.
//    Loads: funct3 101..111 illegal. Illegal/misaligned: granted
//    (consumed) but o_mem_we=0.
//  - o_mem_we = gnt & we & legal.
//  - Latency: load granted in cycle T -> o_rN_rvalid=1, o_rN_rdata=
//    i_mem_rdata sampled at end of T, in cycle T+1 only.
//    Legal stores: no response; memory written at end of T.
//  - Error: illegal access granted in T -> rvalid=1, err=1, rdata=0 in T+1
//    (loads and stores alike).
//  - Back-to-back: a port may be granted every cycle; responses pipeline
//    one per cycle, in order.
//  - Read-after-write same address in T, T+1: load returns the new data.
//  - Legal alignment guarantees addr+1..addr+3 never wrap past the top byte.
//  - Reset mid-operation: pending response in T+1 is suppressed.
// TESTING
//  1 r0 SW 0xDEADBEEF @0x010, then r0 LW @0x010 -> next cycle rvalid=1,
//    rdata=0xDEADBEEF, err=0.
//  2 Both req held 12 cycles, STARVE_LIMIT=4 -> gnt seq r0 r0 r0 r0 r1 r0 r0
//    r0 r0 r1 r0 r0.
//  3 r1 LH @0x003 -> gnt=1, o_mem_we=0; next cycle rvalid=1, err=1, rdata=0.
//  4 r1 SB 0x80 @0x7FF; LBU @0x7FF -> 0x00000080; LB @0x7FF -> 0xFFFFFF80.
//  5 r0 LW granted, i_rst_n=0 next cycle -> rvalid stays 0, cnt=0, gnt=0.
//  6 Only r1 req, 4 LW back-to-back @0,4,8,C -> gnt 4 consecutive cycles,
//    4 consecutive rvalid pulses in address order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port, byte-addressed data memory between two
//   requesters: port 0 (core load/store path, fixed priority) and port 1
//   (DMA / program loader). A starvation counter forces a port-1 grant after
//   STARVE_LIMIT consecutive port-0 grants while port 1 is waiting.
//   Accesses are checked for size/alignment legality; illegal ones are
//   consumed without writing memory and answered with an error response.
//   Load data and error responses come back registered, one cycle after grant.
//
// Ports
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_rN_req/we/addr/wdata/funct3   requester N (0,1) access request
//   o_rN_gnt                   access performed this cycle (combinational)
//   o_rN_rvalid/rdata/err      registered response, one-cycle pulse
//   o_mem_addr/wdata/funct3/we drive the memory with the granted access
//   i_mem_rdata                combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [31:0]       i_r0_wdata,
  input  logic [2:0]        i_r0_funct3,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [31:0]       i_r1_wdata,
  input  logic [2:0]        i_r1_funct3,
  output logic              o_r0_gnt,
  output logic              o_r0_rvalid,
  output logic [31:0]       o_r0_rdata,
  output logic              o_r0_err,
  output logic              o_r1_gnt,
  output logic              o_r1_rvalid,
  output logic [31:0]       o_r1_rdata,
  output logic              o_r1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [2:0]        o_mem_funct3,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // Size/alignment legality. Unsigned sizes only exist for loads.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      3'b000:  ok = 1'b1;
      3'b011:  ok = !we;
      3'b001:  ok = !addr_lo[0];
      3'b100:  ok = !we && !addr_lo[0];
      3'b010:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [CNT_W-1:0]  starve_cnt;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_funct3;
  logic              legal;
  logic              resp;

  logic              vld0_p1;
  logic              vld1_p1;
  logic              err0_p1;
  logic              err1_p1;
  logic [31:0]       rdata0_p1;
  logic [31:0]       rdata1_p1;

  // Stage 0: arbitration, request mux and legality check (combinational).
  // Grants are qualified with i_rst_n so nothing reaches memory in reset.
  always_comb begin
    gnt1       = i_rst_n && i_r1_req && (!i_r0_req || (starve_cnt == CNT_MAX));
    gnt0       = i_rst_n && i_r0_req && !gnt1;
    any_gnt    = gnt0 || gnt1;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_funct3 = '0;
    if (gnt1) begin
      sel_we     = i_r1_we;
      sel_addr   = i_r1_addr;
      sel_wdata  = i_r1_wdata;
      sel_funct3 = i_r1_funct3;
    end else if (gnt0) begin
      sel_we     = i_r0_we;
      sel_addr   = i_r0_addr;
      sel_wdata  = i_r0_wdata;
      sel_funct3 = i_r0_funct3;
    end
    legal = is_legal(sel_we, sel_funct3, sel_addr[1:0]);
    // Loads always answer; stores answer only when they are rejected.
    resp  = any_gnt && (!sel_we || !legal);
  end

  assign o_r0_gnt     = gnt0;
  assign o_r1_gnt     = gnt1;
  assign o_mem_addr   = sel_addr;
  assign o_mem_wdata  = sel_wdata;
  assign o_mem_funct3 = sel_funct3;
  assign o_mem_we     = any_gnt && sel_we && legal;

  // Stage 0 -> 1: starvation counter and registered responses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
      vld0_p1    <= 1'b0;
      vld1_p1    <= 1'b0;
      err0_p1    <= 1'b0;
      err1_p1    <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      if (gnt1 || !i_r1_req) begin
        starve_cnt <= '0;
      end else if (gnt0 && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      vld0_p1 <= gnt0 && resp;
      vld1_p1 <= gnt1 && resp;
      err0_p1 <= gnt0 && resp && !legal;
      err1_p1 <= gnt1 && resp && !legal;
      if (gnt0 && resp) begin
        rdata0_p1 <= legal ? i_mem_rdata : 32'd0;
      end
      if (gnt1 && resp) begin
        rdata1_p1 <= legal ? i_mem_rdata : 32'd0;
      end
    end
  end

  // A response due in the cycle reset is asserted is dropped immediately.
  assign o_r0_rvalid = vld0_p1 && i_rst_n;
  assign o_r0_err    = err0_p1 && i_rst_n;
  assign o_r0_rdata  = i_rst_n ? rdata0_p1 : 32'd0;
  assign o_r1_rvalid = vld1_p1 && i_rst_n;
  assign o_r1_err    = err1_p1 && i_rst_n;
  assign o_r1_rdata  = i_rst_n ? rdata1_p1 : 32'd0;

endmodule
